// File: rtl/decode_stage_pkg.sv
// Shared definitions for the decode stage: opcode/funct codes, ALU-op encoding,
// decoded control bundle and the ID/EX register layout.
package decode_stage_pkg;

  localparam int WORD_LENGTH = 32;
  localparam int REG_COUNT   = 32;
  localparam int REG_IDX_W   = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_SLL = 6'h00;

  localparam logic [WORD_LENGTH-1:0] NOP_INSTR = '0;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLT = 4'd4,
    ALU_SLL = 4'd5
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    alu_src;
    logic    reg_dst;
    logic    is_beq;
    logic    is_bne;
    logic    is_jump;
    logic    uses_rt;
    alu_op_e alu_op;
  } ctrl_t;

  typedef struct packed {
    logic [WORD_LENGTH-1:0] pc4;
    logic [WORD_LENGTH-1:0] rs_data;
    logic [WORD_LENGTH-1:0] rt_data;
    logic [WORD_LENGTH-1:0] imm;
    logic [REG_IDX_W-1:0]   rs;
    logic [REG_IDX_W-1:0]   rt;
    logic [REG_IDX_W-1:0]   dest;
    logic                   reg_write;
    logic                   mem_read;
    logic                   mem_write;
    logic                   alu_src;
    alu_op_e                alu_op;
  } idex_t;

  // uses_rt marks formats whose rt field is a source operand (hazard checks).
  function automatic ctrl_t decode_ctrl(input logic [WORD_LENGTH-1:0] instr);
    ctrl_t c;
    c        = '0;
    c.alu_op = ALU_ADD;
    case (instr[31:26])
      OP_RTYPE: begin
        c.uses_rt = 1'b1;
        if (instr != NOP_INSTR) begin
          c.reg_write = 1'b1;
          c.reg_dst   = 1'b1;
          case (instr[5:0])
            FN_ADD:  c.alu_op = ALU_ADD;
            FN_SUB:  c.alu_op = ALU_SUB;
            FN_AND:  c.alu_op = ALU_AND;
            FN_OR:   c.alu_op = ALU_OR;
            FN_SLT:  c.alu_op = ALU_SLT;
            FN_SLL:  c.alu_op = ALU_SLL;
            default: begin
              c.reg_write = 1'b0;
              c.reg_dst   = 1'b0;
            end
          endcase
        end
      end
      OP_ADDI: begin
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
      end
      OP_LW: begin
        c.reg_write = 1'b1;
        c.mem_read  = 1'b1;
        c.alu_src   = 1'b1;
      end
      OP_SW: begin
        c.mem_write = 1'b1;
        c.alu_src   = 1'b1;
        c.uses_rt   = 1'b1;
      end
      OP_BEQ: begin
        c.is_beq  = 1'b1;
        c.uses_rt = 1'b1;
        c.alu_op  = ALU_SUB;
      end
      OP_BNE: begin
        c.is_bne  = 1'b1;
        c.uses_rt = 1'b1;
        c.alu_op  = ALU_SUB;
      end
      OP_J:    c.is_jump = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Decode-stage bus: fetch inputs/redirect, writeback port, EX hazard info and ID/EX fields.
// master = surrounding pipeline, slave = decode_stage.
interface decode_stage_if;
  import decode_stage_pkg::*;

  logic [WORD_LENGTH-1:0] ifPc4;
  logic [WORD_LENGTH-1:0] ifInstr;
  logic                   wbWrite;
  logic [REG_IDX_W-1:0]   wbAddr;
  logic [WORD_LENGTH-1:0] wbData;
  logic                   exMemRead;
  logic                   exRegWrite;
  logic [REG_IDX_W-1:0]   exDest;
  logic                   pcEnb;
  logic                   BrachTaken;
  logic [WORD_LENGTH-1:0] BranchAddress;
  logic [WORD_LENGTH-1:0] idexPc4;
  logic [WORD_LENGTH-1:0] idexRsData;
  logic [WORD_LENGTH-1:0] idexRtData;
  logic [WORD_LENGTH-1:0] idexImm;
  logic [REG_IDX_W-1:0]   idexRs;
  logic [REG_IDX_W-1:0]   idexRt;
  logic [REG_IDX_W-1:0]   idexDest;
  logic                   idexRegWrite;
  logic                   idexMemRead;
  logic                   idexMemWrite;
  logic                   idexAluSrc;
  logic [3:0]             idexAluOp;

  modport master (
    output ifPc4, ifInstr, wbWrite, wbAddr, wbData, exMemRead, exRegWrite, exDest,
    input  pcEnb, BrachTaken, BranchAddress, idexPc4, idexRsData, idexRtData, idexImm,
           idexRs, idexRt, idexDest, idexRegWrite, idexMemRead, idexMemWrite,
           idexAluSrc, idexAluOp
  );

  modport slave (
    input  ifPc4, ifInstr, wbWrite, wbAddr, wbData, exMemRead, exRegWrite, exDest,
    output pcEnb, BrachTaken, BranchAddress, idexPc4, idexRsData, idexRtData, idexImm,
           idexRs, idexRt, idexDest, idexRegWrite, idexMemRead, idexMemWrite,
           idexAluSrc, idexAluOp
  );
endinterface

// File: rtl/decode_stage_register_file.sv
// 32x32 register file: two async reads, one sync write, r0 reads as zero.
// DECODE_BYPASS_EN forwards same-cycle writeback data onto the read ports.
module register_file
  import decode_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REG_IDX_W-1:0]   rs_addr_i,
  input  logic [REG_IDX_W-1:0]   rt_addr_i,
  output logic [WORD_LENGTH-1:0] rs_data_o,
  output logic [WORD_LENGTH-1:0] rt_data_o,
  input  logic                   wr_en_i,
  input  logic [REG_IDX_W-1:0]   wr_addr_i,
  input  logic [WORD_LENGTH-1:0] wr_data_i
);

  logic [WORD_LENGTH-1:0] regs_q [REG_COUNT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en_i && (wr_addr_i != '0)) begin
      regs_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_comb begin
    rs_data_o = (rs_addr_i == '0) ? '0 : regs_q[rs_addr_i];
    rt_data_o = (rt_addr_i == '0) ? '0 : regs_q[rt_addr_i];
`ifdef DECODE_BYPASS_EN
    if (wr_en_i && (wr_addr_i != '0) && (wr_addr_i == rs_addr_i)) rs_data_o = wr_data_i;
    if (wr_en_i && (wr_addr_i != '0) && (wr_addr_i == rt_addr_i)) rt_data_o = wr_data_i;
`endif
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: IF/ID register, register file, decoder, branch resolution in ID,
// load-use/branch hazard stall and ID/EX register. Optional macro: DECODE_BYPASS_EN.
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  decode_stage_if.slave bus
);

  logic [WORD_LENGTH-1:0] if_id_pc4_q, if_id_pc4_d;
  logic [WORD_LENGTH-1:0] if_id_instr_q, if_id_instr_d;
  idex_t                  idex_q, idex_d;

  logic [REG_IDX_W-1:0]   rs, rt, rd;
  logic [WORD_LENGTH-1:0] imm, rs_data, rt_data, branch_target;
  ctrl_t                  ctrl;
  logic                   load_use, branch_hazard, stall, branch_taken, operands_equal;

  assign rs   = if_id_instr_q[25:21];
  assign rt   = if_id_instr_q[20:16];
  assign rd   = if_id_instr_q[15:11];
  assign imm  = {{16{if_id_instr_q[15]}}, if_id_instr_q[15:0]};
  assign ctrl = decode_ctrl(if_id_instr_q);

  register_file u_register_file (
    .clk       (clk),
    .rst       (rst),
    .rs_addr_i (rs),
    .rt_addr_i (rt),
    .rs_data_o (rs_data),
    .rt_data_o (rt_data),
    .wr_en_i   (bus.wbWrite),
    .wr_addr_i (bus.wbAddr),
    .wr_data_i (bus.wbData)
  );

  // A stalled branch must not redirect: its operands are not final yet.
  always_comb begin
    load_use = bus.exMemRead && (bus.exDest != '0) &&
               ((bus.exDest == rs) || (ctrl.uses_rt && (bus.exDest == rt)));
    branch_hazard = (ctrl.is_beq || ctrl.is_bne) && bus.exRegWrite && (bus.exDest != '0) &&
                    ((bus.exDest == rs) || (bus.exDest == rt));
    stall          = load_use || branch_hazard;
    operands_equal = (rs_data == rt_data);
    branch_taken   = !stall && ((ctrl.is_beq && operands_equal) ||
                                (ctrl.is_bne && !operands_equal) || ctrl.is_jump);
    branch_target  = ctrl.is_jump ? {if_id_pc4_q[31:28], if_id_instr_q[25:0], 2'b00}
                                  : if_id_pc4_q + {imm[29:0], 2'b00};
  end

  always_comb begin
    if_id_pc4_d   = if_id_pc4_q;
    if_id_instr_d = if_id_instr_q;
    if (!stall) begin
      if (branch_taken) begin
        if_id_pc4_d   = '0;
        if_id_instr_d = NOP_INSTR;
      end else begin
        if_id_pc4_d   = bus.ifPc4;
        if_id_instr_d = bus.ifInstr;
      end
    end

    idex_d = '0;
    if (!stall) begin
      idex_d.pc4       = if_id_pc4_q;
      idex_d.rs_data   = rs_data;
      idex_d.rt_data   = rt_data;
      idex_d.imm       = imm;
      idex_d.rs        = rs;
      idex_d.rt        = rt;
      idex_d.dest      = ctrl.reg_dst ? rd : rt;
      idex_d.reg_write = ctrl.reg_write;
      idex_d.mem_read  = ctrl.mem_read;
      idex_d.mem_write = ctrl.mem_write;
      idex_d.alu_src   = ctrl.alu_src;
      idex_d.alu_op    = ctrl.alu_op;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_id_pc4_q   <= '0;
      if_id_instr_q <= '0;
      idex_q        <= '0;
    end else begin
      if_id_pc4_q   <= if_id_pc4_d;
      if_id_instr_q <= if_id_instr_d;
      idex_q        <= idex_d;
    end
  end

  assign bus.pcEnb         = !stall;
  assign bus.BrachTaken    = branch_taken;
  assign bus.BranchAddress = branch_target;
  assign bus.idexPc4       = idex_q.pc4;
  assign bus.idexRsData    = idex_q.rs_data;
  assign bus.idexRtData    = idex_q.rt_data;
  assign bus.idexImm       = idex_q.imm;
  assign bus.idexRs        = idex_q.rs;
  assign bus.idexRt        = idex_q.rt;
  assign bus.idexDest      = idex_q.dest;
  assign bus.idexRegWrite  = idex_q.reg_write;
  assign bus.idexMemRead   = idex_q.mem_read;
  assign bus.idexMemWrite  = idex_q.mem_write;
  assign bus.idexAluSrc    = idex_q.alu_src;
  assign bus.idexAluOp     = idex_q.alu_op;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expected ID/EX contents are queued when an
// instruction sits in ID and compared one clock later; redirect/stall checked directly.
`timescale 1ns/1ps
module tb_decode_stage;

  localparam logic [159:0] ZERO = '0;

  logic clk = 1'b0;
  logic rst;
  decode_stage_if bus ();

  decode_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int           n_checks;
  int           n_errors;
  logic [159:0] exp_q[$];
  logic [31:0]  model_rf [32];
  logic [5:0]   fn_tab [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
  logic [3:0]   op_tab [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5};

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [159:0] idex_pack(
    input logic [31:0] pc4, input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
    input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dest,
    input logic rw, input logic mr, input logic mw, input logic as, input logic [3:0] op);
    return {9'd0, pc4, rsd, rtd, imm, rs, rt, dest, rw, mr, mw, as, op};
  endfunction

  function automatic logic [159:0] idex_obs();
    return idex_pack(bus.idexPc4, bus.idexRsData, bus.idexRtData, bus.idexImm,
                     bus.idexRs, bus.idexRt, bus.idexDest, bus.idexRegWrite,
                     bus.idexMemRead, bus.idexMemWrite, bus.idexAluSrc, bus.idexAluOp);
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] sext16(input logic [31:0] ins);
    return {{16{ins[15]}}, ins[15:0]};
  endfunction

  task automatic fetch(input logic [31:0] pc4, input logic [31:0] instr);
    bus.ifPc4   = pc4;
    bus.ifInstr = instr;
  endtask

  task automatic wb(input logic en, input logic [4:0] addr, input logic [31:0] data);
    bus.wbWrite = en;
    bus.wbAddr  = addr;
    bus.wbData  = data;
  endtask

  task automatic ex(input logic mem_read, input logic reg_write, input logic [4:0] dest);
    bus.exMemRead  = mem_read;
    bus.exRegWrite = reg_write;
    bus.exDest     = dest;
  endtask

  task automatic model_write(input logic [4:0] addr, input logic [31:0] data);
    if (addr != 5'd0) model_rf[addr] = data;
  endtask

  task automatic cycle(input string tag);
    logic [159:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check(tag, idex_obs(), e);
    end
  endtask

  // Starts and ends with a nop in ID.
  task automatic issue(input string tag, input logic [31:0] pc4, input logic [31:0] instr,
                       input logic [159:0] exp);
    fetch(pc4, instr);
    exp_q.push_back(ZERO);
    cycle("pre_issue_nop");
    fetch(32'h0, 32'h0);
    exp_q.push_back(exp);
    cycle(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] instr, instr2, byp, pc4;
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 32; i++) model_rf[i] = '0;
    rst = 1'b1;
    fetch(32'h0, 32'h0);
    wb(1'b0, 5'd0, 32'h0);
    ex(1'b0, 1'b0, 5'd0);
    #7;
    check("rst_idex", idex_obs(), ZERO);
    check("rst_pcEnb", 160'(bus.pcEnb), 160'(1));
    check("rst_taken", 160'(bus.BrachTaken), 160'(0));
    check("rst_target", 160'(bus.BranchAddress), 160'(0));
    #5;
    rst = 1'b0;

    // addi r1,r0,7 then writeback r1=7
    instr = enc_i(6'h08, 5'd0, 5'd1, 16'd7);
    issue("addi_r1", 32'h4, instr,
          idex_pack(32'h4, 32'h0, model_rf[1], 32'd7, 5'd0, 5'd1, 5'd1, 1, 0, 0, 1, 4'd0));
    wb(1'b1, 5'd1, 32'd7);
    exp_q.push_back(ZERO);
    cycle("wb_r1");
    wb(1'b0, 5'd0, 32'h0);
    model_write(5'd1, 32'd7);

    // beq r1,r1,+3 at pc4 0x100: taken, target 0x10C, fetch slot flushed
    instr = enc_i(6'h04, 5'd1, 5'd1, 16'd3);
    fetch(32'h100, instr);
    exp_q.push_back(ZERO);
    cycle("pre_beq");
    fetch(32'h104, enc_i(6'h08, 5'd0, 5'd9, 16'd1));
    #1;
    check("beq_taken", 160'(bus.BrachTaken), 160'(1));
    check("beq_target", 160'(bus.BranchAddress), 160'(32'h10C));
    check("beq_pcEnb", 160'(bus.pcEnb), 160'(1));
    exp_q.push_back(idex_pack(32'h100, 32'd7, 32'd7, 32'd3, 5'd1, 5'd1, 5'd1, 0, 0, 0, 0, 4'd1));
    cycle("beq_idex");
    fetch(32'h0, 32'h0);
    #1;
    check("flush_taken", 160'(bus.BrachTaken), 160'(0));
    exp_q.push_back(ZERO);
    cycle("beq_flush");

    // load-use: lw r2 in EX, add r3,r2,r4 in ID
    wb(1'b1, 5'd4, 32'h44);
    exp_q.push_back(ZERO);
    cycle("wb_r4");
    wb(1'b0, 5'd0, 32'h0);
    model_write(5'd4, 32'h44);
    instr  = enc_r(5'd2, 5'd4, 5'd3, 5'd0, 6'h20);
    instr2 = enc_r(5'd4, 5'd4, 5'd5, 5'd0, 6'h22);
    fetch(32'h200, instr);
    exp_q.push_back(ZERO);
    cycle("pre_add");
    fetch(32'h204, instr2);
    ex(1'b1, 1'b1, 5'd2);
    #1;
    check("lu_pcEnb", 160'(bus.pcEnb), 160'(0));
    exp_q.push_back(ZERO);
    cycle("lu_bubble");
    ex(1'b0, 1'b0, 5'd0);
    #1;
    check("lu_release", 160'(bus.pcEnb), 160'(1));
    exp_q.push_back(idex_pack(32'h200, model_rf[2], model_rf[4], sext16(instr),
                              5'd2, 5'd4, 5'd3, 1, 0, 0, 0, 4'd0));
    cycle("lu_add_issue");
    fetch(32'h0, 32'h0);
    exp_q.push_back(idex_pack(32'h204, model_rf[4], model_rf[4], sext16(instr2),
                              5'd4, 5'd4, 5'd5, 1, 0, 0, 0, 4'd1));
    cycle("sub_issue");

    // bne r4,r0 with EX writing r4: stall beats the taken branch
    instr = enc_i(6'h05, 5'd4, 5'd0, 16'd1);
    fetch(32'h300, instr);
    exp_q.push_back(ZERO);
    cycle("pre_bne");
    fetch(32'h304, enc_i(6'h08, 5'd0, 5'd13, 16'd1));
    ex(1'b0, 1'b1, 5'd4);
    #1;
    check("bh_pcEnb", 160'(bus.pcEnb), 160'(0));
    check("bh_taken", 160'(bus.BrachTaken), 160'(0));
    exp_q.push_back(ZERO);
    cycle("bh_bubble");
    ex(1'b0, 1'b0, 5'd0);
    #1;
    check("bne_taken", 160'(bus.BrachTaken), 160'(1));
    check("bne_target", 160'(bus.BranchAddress), 160'(32'h304));
    exp_q.push_back(idex_pack(32'h300, 32'h44, 32'h0, 32'd1, 5'd4, 5'd0, 5'd0, 0, 0, 0, 0, 4'd1));
    cycle("bne_idex");
    fetch(32'h0, 32'h0);
    exp_q.push_back(ZERO);
    cycle("bne_flush");

    // j 0x40 with pc4 0x8000_0010
    fetch(32'h8000_0010, 32'h0800_0040);
    exp_q.push_back(ZERO);
    cycle("pre_j");
    fetch(32'h0, 32'h0);
    #1;
    check("j_taken", 160'(bus.BrachTaken), 160'(1));
    check("j_target", 160'(bus.BranchAddress), 160'(32'h8000_0100));
    exp_q.push_back(idex_pack(32'h8000_0010, 32'h0, 32'h0, 32'h40, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 4'd0));
    cycle("j_idex");
    exp_q.push_back(ZERO);
    cycle("j_flush");

    // writing r0 has no effect
    instr = enc_i(6'h08, 5'd0, 5'd8, 16'd5);
    fetch(32'h400, instr);
    wb(1'b1, 5'd0, 32'hFFFF);
    exp_q.push_back(ZERO);
    cycle("wb_r0");
    wb(1'b0, 5'd0, 32'h0);
    fetch(32'h0, 32'h0);
    exp_q.push_back(idex_pack(32'h400, 32'h0, model_rf[8], 32'd5, 5'd0, 5'd8, 5'd8, 1, 0, 0, 1, 4'd0));
    cycle("addi_r0_read");
    check("r0_read", 160'(bus.idexRsData), 160'(0));

    // same-cycle writeback and read of r6
    wb(1'b1, 5'd6, 32'h11);
    exp_q.push_back(ZERO);
    cycle("wb_r6_old");
    wb(1'b0, 5'd0, 32'h0);
    model_write(5'd6, 32'h11);
    instr = enc_r(5'd6, 5'd0, 5'd9, 5'd0, 6'h20);
    fetch(32'h500, instr);
    exp_q.push_back(ZERO);
    cycle("pre_bypass");
    fetch(32'h0, 32'h0);
    wb(1'b1, 5'd6, 32'h55);
`ifdef DECODE_BYPASS_EN
    byp = 32'h55;
`else
    byp = model_rf[6];
`endif
    exp_q.push_back(idex_pack(32'h500, byp, 32'h0, sext16(instr), 5'd6, 5'd0, 5'd9, 1, 0, 0, 0, 4'd0));
    cycle("bypass_rs");
    wb(1'b0, 5'd0, 32'h0);
    model_write(5'd6, 32'h55);

    // lw, sw and an unsupported opcode
    instr = enc_i(6'h23, 5'd6, 5'd10, 16'h0008);
    issue("lw", 32'h510, instr,
          idex_pack(32'h510, model_rf[6], model_rf[10], 32'd8, 5'd6, 5'd10, 5'd10, 1, 1, 0, 1, 4'd0));
    instr = enc_i(6'h2B, 5'd6, 5'd4, 16'hFFFC);
    issue("sw", 32'h514, instr,
          idex_pack(32'h514, model_rf[6], model_rf[4], 32'hFFFF_FFFC, 5'd6, 5'd4, 5'd4, 0, 0, 1, 1, 4'd0));
    issue("unsupported", 32'h518, 32'hFC00_0000,
          idex_pack(32'h518, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 4'd0));

    // fill the register file with random data, then random R-type / addi
    for (int r = 1; r < 32; r++) begin
      logic [31:0] d;
      d = $urandom();
      wb(1'b1, 5'(r), d);
      exp_q.push_back(ZERO);
      cycle("fill");
      model_write(5'(r), d);
    end
    wb(1'b1, 5'd5, 32'h77);
    exp_q.push_back(ZERO);
    cycle("fill_r5");
    model_write(5'd5, 32'h77);
    wb(1'b0, 5'd0, 32'h0);

    pc4 = 32'h1000;
    for (int n = 0; n < 16; n++) begin
      logic [4:0] rs, rt, rd;
      logic [159:0] e;
      int k;
      rs = 5'($urandom_range(1, 31));
      rt = 5'($urandom_range(1, 31));
      rd = 5'($urandom_range(1, 31));
      if ($urandom_range(0, 1) == 1) begin
        k = $urandom_range(0, 5);
        instr = enc_r(rs, rt, rd, 5'($urandom_range(0, 31)), fn_tab[k]);
        e = idex_pack(pc4, model_rf[rs], model_rf[rt], sext16(instr), rs, rt, rd, 1, 0, 0, 0, op_tab[k]);
      end else begin
        instr = enc_i(6'h08, rs, rt, 16'($urandom_range(0, 65535)));
        e = idex_pack(pc4, model_rf[rs], model_rf[rt], sext16(instr), rs, rt, rt, 1, 0, 0, 1, 4'd0);
      end
      issue("rand_decode", pc4, instr, e);
      pc4 = pc4 + 32'd4;
    end

    // asynchronous reset while addi sits in ID and ID/EX is loaded
    instr = enc_i(6'h08, 5'd0, 5'd5, 16'd9);
    fetch(32'h600, instr);
    exp_q.push_back(ZERO);
    cycle("pre_rst_addi");
    fetch(32'h604, instr);
    exp_q.push_back(idex_pack(32'h600, 32'h0, model_rf[5], 32'd9, 5'd0, 5'd5, 5'd5, 1, 0, 0, 1, 4'd0));
    cycle("rst_addi_idex");
    #1;
    rst = 1'b1;
    #1;
    check("midrst_idex", idex_obs(), ZERO);
    check("midrst_pcEnb", 160'(bus.pcEnb), 160'(1));
    check("midrst_taken", 160'(bus.BrachTaken), 160'(0));
    #1;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) model_rf[i] = '0;
    exp_q.delete();
    fetch(32'h0, 32'h0);

    instr = enc_r(5'd5, 5'd0, 5'd11, 5'd0, 6'h20);
    issue("post_rst_read", 32'h700, instr,
          idex_pack(32'h700, model_rf[5], 32'h0, sext16(instr), 5'd5, 5'd0, 5'd11, 1, 0, 0, 0, 4'd0));
    check("r5_after_rst", 160'(bus.idexRsData), 160'(0));

    check("queue_empty", 160'(exp_q.size()), 160'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Second pipeline stage; consumes fetch-stage outputs (PC+4, instruction word) and returns branch target, branch-taken and PC enable to fetch.
- Contains the IF/ID pipeline register, the 32x32 register file, the opcode decoder, branch resolution, load-use/branch hazard detection and the ID/EX pipeline register.
- Branches and jumps resolve in ID, so a taken branch costs one flushed slot.

Parameters:
- WORD_LENGTH, 32, datapath width. Only 32 is supported.
- REG_COUNT, 32, number of architectural registers. Register 0 is hardwired to zero.

Ports:
- clk  in  1  stage clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ifPc4  in  32  PC+4 from fetch
- ifInstr  in  32  instruction from fetch
- wbWrite  in  1  writeback write enable
- wbAddr  in  5  writeback destination register
- wbData  in  32  writeback data
- exMemRead  in  1  instruction currently in EX is a load
- exRegWrite  in  1  instruction currently in EX writes a register
- exDest  in  5  destination register of the instruction in EX
- pcEnb  out  1  fetch PC enable (=!stall)
- BrachTaken  out  1  redirect fetch
- BranchAddress  out  32  redirect target
- idexPc4, idexRsData, idexRtData, idexImm  out  32 each  ID/EX datapath fields
- idexRs, idexRt, idexDest  out  5 each  register indices (idexDest is already RegDst-selected)
- idexRegWrite, idexMemRead, idexMemWrite, idexAluSrc  out  1 each  control fields
- idexAluOp  out  4  ALU operation (package encoding)

Behaviour:
- Reset (async): IF/ID register, ID/EX register and all register-file entries go to 0. Every output is 0 except pcEnb, which is 1 (no stall with a nop in ID). Instruction 0 decodes as a nop (sll r0), so no control fields are set.
- IF/ID register update at clk, in priority order:
  - stall: hold contents.
  - BrachTaken: load 0 (flush).
  - otherwise: load {ifPc4, ifInstr}.
- Decode. Supported opcodes:
  - R-type 0x00: funct add/sub/and/or/slt/sll
  - addi 0x08, lw 0x23, sw 0x2B, beq 0x04, bne 0x05, j 0x02
  - Any other opcode decodes as a nop: all control 0.
- Immediate: sign-extended instr[15:0].
- Register file:
  - Combinational reads at rs=instr[25:21] and rt=instr[20:16].
  - Write on the rising edge when wbWrite=1 and wbAddr!=0.
  - Reads of r0 always return 0.
- Branch resolution (combinational from IF/ID contents):
  - beq: taken if rsData==rtData. bne: taken if rsData!=rtData.
  - Branch target = idPc4 + (imm<<2), computed modulo 2^32 (wrap-around ignored).
  - j: always taken; target = {idPc4[31:28], instr[25:0], 2'b00}.
  - BrachTaken is forced to 0 while stall=1.
- Stall (combinational) is asserted when either:
  - exMemRead and exDest!=0 and exDest matches rs or rt (load-use); rt is checked only for R-type, beq, bne and sw.
  - The instruction in ID is beq/bne, exRegWrite=1, exDest!=0, and exDest matches rs or rt.
- ID/EX register update at clk:
  - stall: load a bubble (all fields 0).
  - otherwise: load the decoded fields.
  - Latency: an instruction present in IF/ID in cycle n appears on the idex* outputs in cycle n+1.
- Simultaneous events:
  - stall with a would-be taken branch: stall wins; the branch resolves in a later cycle.
  - Writeback to rs/rt in the same cycle as the read: behaviour is set by DECODE_BYPASS_EN.
  - rst asserted mid-operation: immediate clear regardless of clk; in-flight instructions are lost.

Optional Feature:
- Macro: DECODE_BYPASS_EN.
- Defined: when wbWrite=1, wbAddr!=0 and wbAddr equals the rs/rt read address, the read data (for the ID/EX fields and the branch comparator) is wbData in the same cycle.
- Undefined: the read returns the old register contents. Software must separate the dependent instructions by one extra slot.

Decomposition:
- Shared package: opcode/funct constants, ALU-op 4-bit encoding (ADD=0, SUB=1, AND=2, OR=3, SLT=4, SLL=5), a NOP instruction constant, and the register-index width.
- Sub-module: register_file (two async read ports, one sync write port, async reset, r0 hardwired to zero). The bypass mux sits in register_file under the macro.

Test Plan:
- Reset mid-run: assert rst while addi is in ID → all idex* outputs 0 immediately, pcEnb=1, reading r5 afterwards returns 0.
- addi r1,r0,7 then wbWrite r1=7, then beq r1,r1,+3 with ifPc4=0x100 → BrachTaken=1, BranchAddress=0x10C, next IF/ID=0.
- Load-use: lw r2 in EX (exMemRead=1, exDest=2), add r3,r2,r4 in ID → pcEnb=0, IF/ID held, ID/EX bubble; next cycle pcEnb=1 and the add issues.
- j 0x0000040 with idPc4=0x8000_0010 → BranchAddress=0x8000_0100, BrachTaken=1.
- Write r0 with 0xFFFF via WB, then read rs=0 → idexRsData=0.
- Same-cycle WB r6=0x55 plus read r6 → 0x55 when DECODE_BYPASS_EN is defined, old value when undefined.
